// File: rtl/fft_twiddle_mul.sv
// ============================================================================
// Module   : fft_twiddle_mul
// Purpose  : Twiddle-multiply stage of the 8-point FFT datapath. Tags each
//            incoming complex sample with a 3-bit twiddle index, drives that
//            index to an external combinational twiddle ROM, multiplies the
//            sample by the returned Q2.7 coefficient, rounds half-up and
//            range-limits the product. Fixed 2-cycle latency, 1 sample/cycle.
// Ports    : clk                rising-edge clock
//            rst_n              asynchronous active-low reset
//            in_valid           sample present (no backpressure)
//            in_sof             first sample of a frame (with in_valid)
//            in_re, in_im       signed DW-bit sample
//            tw_addr            twiddle ROM address (combinational)
//            tw_re, tw_im       signed Q2.7 twiddle, same cycle as tw_addr
//            out_valid          result present
//            out_last           result carries index 7
//            out_re, out_im     signed OW-bit result
// Config   : FFT_TWMUL_SAT_EN   defined   -> clamp result to OW-bit range
//                               undefined -> keep low OW bits (wrap)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_twiddle_mul #(
  parameter int DW = 9,
  parameter int OW = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic [2:0]           tw_addr,
  input  logic signed [9:0]    tw_re,
  input  logic signed [9:0]    tw_im,
  output logic                 out_valid,
  output logic                 out_last,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im
);

  // Product, sum and rounded widths
  localparam int PW = DW + 10;
  localparam int SW = DW + 11;
  localparam int RW = DW + 4;

  localparam logic signed [SW-1:0] C_HALF = SW'(64);

  // ---------------------------------------------------------------------------
  // Index counter
  // ---------------------------------------------------------------------------
  logic [2:0] idx_q, idx_d;

  always_comb begin
    // in_sof forces index 0 for this sample; the count resumes from there
    tw_addr = in_sof ? 3'd0 : idx_q;
    idx_d   = idx_q;
    if (in_valid) begin
      idx_d = tw_addr + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: four partial products
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic                 v1_q, v1_d;
  logic                 l1_q, l1_d;

  always_comb begin
    p_rr_d = p_rr_q;
    p_ii_d = p_ii_q;
    p_ri_d = p_ri_q;
    p_ir_d = p_ir_q;
    l1_d   = l1_q;
    v1_d   = in_valid;
    if (in_valid) begin
      // Operands widened first so the full DW+10-bit product is kept
      p_rr_d = PW'(in_re) * PW'(tw_re);
      p_ii_d = PW'(in_im) * PW'(tw_im);
      p_ri_d = PW'(in_re) * PW'(tw_im);
      p_ir_d = PW'(in_im) * PW'(tw_re);
      l1_d   = (tw_addr == 3'd7);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: combine, round half-up, range-limit
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] re_s, im_s;
  logic signed [SW-1:0] re_rnd, im_rnd;
  logic signed [RW-1:0] re_sh, im_sh;
  logic signed [OW-1:0] re_lim, im_lim;

  always_comb begin
    re_s   = SW'(p_rr_q) - SW'(p_ii_q);
    im_s   = SW'(p_ri_q) + SW'(p_ir_q);
    re_rnd = re_s + C_HALF;
    im_rnd = im_s + C_HALF;
    // Dropping the 7 fractional bits is the arithmetic shift right by 7
    re_sh  = re_rnd[SW-1:7];
    im_sh  = im_rnd[SW-1:7];
  end

`ifdef FFT_TWMUL_SAT_EN
  localparam logic signed [RW-1:0] C_MAX = RW'((1 << (OW - 1)) - 1);
  localparam logic signed [RW-1:0] C_MIN = ~C_MAX;
  localparam logic signed [OW-1:0] C_OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] C_OMIN = {1'b1, {(OW-1){1'b0}}};

  always_comb begin
    re_lim = re_sh[OW-1:0];
    im_lim = im_sh[OW-1:0];
    if (re_sh > C_MAX) begin
      re_lim = C_OMAX;
    end else if (re_sh < C_MIN) begin
      re_lim = C_OMIN;
    end
    if (im_sh > C_MAX) begin
      im_lim = C_OMAX;
    end else if (im_sh < C_MIN) begin
      im_lim = C_OMIN;
    end
  end

  logic unused_frac;
  assign unused_frac = ^{re_rnd[6:0], im_rnd[6:0]};
`else
  // Two's-complement wrap: keep only the low OW bits
  always_comb begin
    re_lim = re_sh[OW-1:0];
    im_lim = im_sh[OW-1:0];
  end

  logic unused_frac;
  assign unused_frac = ^{re_rnd[6:0], im_rnd[6:0], re_sh[RW-1:OW], im_sh[RW-1:OW]};
`endif

  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic signed [OW-1:0] out_re_q, out_re_d;
  logic signed [OW-1:0] out_im_q, out_im_d;

  always_comb begin
    out_valid_d = v1_q;
    out_last_d  = l1_q & v1_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    // Output data holds across gaps so the bus stays quiet
    if (v1_q) begin
      out_re_d = re_lim;
      out_im_d = im_lim;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 3'd0;
      p_rr_q      <= '0;
      p_ii_q      <= '0;
      p_ri_q      <= '0;
      p_ir_q      <= '0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      idx_q       <= idx_d;
      p_rr_q      <= p_rr_d;
      p_ii_q      <= p_ii_d;
      p_ri_q      <= p_ri_d;
      p_ir_q      <= p_ir_d;
      v1_q        <= v1_d;
      l1_q        <= l1_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

`default_nettype wire
